// File: rtl/isa_bus_initiator.sv
// ============================================================================
// isa_bus_initiator
//
// CPU-side ISA bus master. Runs one 8-bit I/O or memory cycle at a time
// toward the video adapter and returns a one-cycle response pulse.
//
// Cycle shape (one clk domain):
//   IDLE -> SETUP (address/AEN stable, strobes high)
//        -> STROBE (selected strobe low, minimum width)
//        -> WAIT   (strobe stays low while the card holds bus_rdy low)
//        -> HOLD   (strobe high, address/data/AEN held)
//        -> RESP   (rsp_valid pulse, AEN released) -> IDLE
//
// Parameters:
//   SETUP_CYCLES  - cycles address/AEN settle before the strobe falls (min 1)
//   STROBE_CYCLES - minimum strobe-low cycles before bus_rdy matters (min 1)
//   HOLD_CYCLES   - cycles address/data held after the strobe rises (min 1)
//   RDY_TIMEOUT   - WAIT cycles before abort (only with ISA_RDY_TIMEOUT_EN)
//
// Optional feature macro: ISA_RDY_TIMEOUT_EN
//   defined   - a stuck bus_rdy aborts the cycle after RDY_TIMEOUT WAIT
//               cycles; rsp_err=1 and reads return 8'hFF.
//   undefined - WAIT lasts indefinitely and rsp_err is tied 0.
//
// Ports:
//   clk, reset_l            clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only in IDLE)
//   req_write, req_mem      cycle type: {mem, write} selects the strobe
//   req_addr, req_wdata     target address and write data
//   rsp_valid               one-cycle completion pulse
//   rsp_rdata, rsp_err      read data, timeout flag
//   busy                    high whenever a cycle is in progress
//   bus_a, bus_d, bus_aen   ISA address, write data, address enable
//   bus_ior_l .. bus_memw_l active-low strobes (registered, glitch-free)
//   bus_out, bus_dir        card read data and its drive indication
//   bus_rdy                 0 = card requests a wait state
// ============================================================================
module isa_bus_initiator #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 1,
    parameter int RDY_TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_mem,
    input  logic [14:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [14:0] bus_a,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic [7:0]  bus_d,
    output logic        bus_aen,
    input  logic [7:0]  bus_out,
    input  logic        bus_dir,
    input  logic        bus_rdy
);

    // Zero-length phases are stretched to one cycle.
    localparam int SETUP_N  = (SETUP_CYCLES  < 1) ? 1 : SETUP_CYCLES;
    localparam int STROBE_N = (STROBE_CYCLES < 1) ? 1 : STROBE_CYCLES;
    localparam int HOLD_N   = (HOLD_CYCLES   < 1) ? 1 : HOLD_CYCLES;

    localparam logic [31:0] SETUP_LAST  = 32'(SETUP_N - 1);
    localparam logic [31:0] STROBE_LAST = 32'(STROBE_N - 1);
    localparam logic [31:0] HOLD_LAST   = 32'(HOLD_N - 1);

`ifdef ISA_RDY_TIMEOUT_EN
    localparam int          TIMEOUT_N    = (RDY_TIMEOUT < 1) ? 1 : RDY_TIMEOUT;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_N - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_HOLD,
        S_RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [31:0] phase_cnt;   // cycles spent in the current state
    logic        write_q;
    logic        mem_q;
    logic        accept;
    logic        sample;      // capture read data on this edge
    logic        abort;       // WAIT timed out on this edge
    logic        strobe_on;
    logic        aen_on;

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = req_ready && req_valid;

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        sample     = 1'b0;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) next_state = S_SETUP;
            end
            S_SETUP: begin
                if (phase_cnt == SETUP_LAST) next_state = S_STROBE;
            end
            S_STROBE: begin
                // bus_rdy only matters on the last minimum-width cycle.
                if (phase_cnt == STROBE_LAST) begin
                    if (bus_rdy) begin
                        sample     = 1'b1;
                        next_state = S_HOLD;
                    end else begin
                        next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (bus_rdy) begin
                    sample     = 1'b1;
                    next_state = S_HOLD;
                end
`ifdef ISA_RDY_TIMEOUT_EN
                else if (phase_cnt == TIMEOUT_LAST) begin
                    abort      = 1'b1;
                    next_state = S_HOLD;
                end
`endif
            end
            S_HOLD: begin
                if (phase_cnt == HOLD_LAST) next_state = S_RESP;
            end
            S_RESP: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Bus outputs are registered from the next state so they change only
    // at clock edges and line up with the state they belong to.
    assign strobe_on = (next_state == S_STROBE) || (next_state == S_WAIT);
    assign aen_on    = (next_state == S_SETUP) || (next_state == S_STROBE) ||
                       (next_state == S_WAIT)  || (next_state == S_HOLD);

    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others regardless of statement order.
    // NOTE: every register has an explicit reset value; the async reset
    // drives strobes and AEN inactive immediately, without waiting for clk.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            write_q    <= 1'b0;
            mem_q      <= 1'b0;
            bus_a      <= '0;
            bus_d      <= '0;
            bus_aen    <= 1'b1;
            bus_ior_l  <= 1'b1;
            bus_iow_l  <= 1'b1;
            bus_memr_l <= 1'b1;
            bus_memw_l <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            state     <= next_state;
            phase_cnt <= (next_state != state) ? '0 : phase_cnt + 32'd1;

            if (accept) begin
                write_q <= req_write;
                mem_q   <= req_mem;
                bus_a   <= req_addr;
                bus_d   <= req_wdata;
            end

            bus_aen    <= !aen_on;
            bus_ior_l  <= !(strobe_on && !mem_q && !write_q);
            bus_iow_l  <= !(strobe_on && !mem_q &&  write_q);
            bus_memr_l <= !(strobe_on &&  mem_q && !write_q);
            bus_memw_l <= !(strobe_on &&  mem_q &&  write_q);

            rsp_valid <= (next_state == S_RESP);

            // Writes leave rsp_rdata untouched; an undriven bus reads 8'hFF.
            if (!write_q) begin
                if (sample)     rsp_rdata <= bus_dir ? bus_out : 8'hFF;
                else if (abort) rsp_rdata <= 8'hFF;
            end
        end
    end

`ifdef ISA_RDY_TIMEOUT_EN
    logic err_q;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign rsp_err = err_q;
`else
    logic unused_rdy_timeout;

    assign rsp_err            = 1'b0;
    assign unused_rdy_timeout = (RDY_TIMEOUT != 0);
`endif

endmodule
